tc_result_tx: RTL
=================

Name: tc_result_tx

Overview:
- Transmit side of the tensor-core AXI path, complementing the receive-side `recvbits` configuration.
- Fetches the final C tile row by row from the PE result regfile once the array reaches FINISH.
- Packs each row into fixed-width beats and streams them out on a valid/ready (AXI-Stream style) interface, with tx_last on the final beat of the tile.
- The tile shape (m16n16k16, m8n32k16, m32n8k16) and the unit width (16-bit for INT4, 32-bit otherwise) are latched at start.

Parameters:
- TX_BITS, 128, output beat width in bits; must be a multiple of 32 and ≤ 256.
- MAX_N, 32, maximum row length in elements; sets rd_data width.
- UNIT_W, 32, maximum regfile unit width in bits.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse when the array state becomes FINISH
- shape_i  in  2  0=m16n16, 1=m8n32, 2=m32n8, 3=illegal
- unit16_i  in  1  1 = INT4 (16-bit units), 0 = 32-bit units
- rd_req  out  1  row read strobe to the result regfile
- rd_row  out  5  row index being read
- rd_data  in  MAX_N*UNIT_W  row data; valid the cycle after rd_req; element j at [j*U +: U]
- tx_valid  out  1  beat valid
- tx_ready  in  1  sink ready
- tx_data  out  TX_BITS  beat payload
- tx_last  out  1  final beat of the tile
- busy  out  1  high from the first cycle after an accepted start until done
- done  out  1  one-cycle pulse after the final handshake

Behaviour:
- Reset (asynchronous, any state): go to IDLE. rd_req, tx_valid, tx_last, busy and done = 0; tx_data = 0; row and beat counters = 0. Any in-flight beat is dropped.
- Latched at start: M/N = 16/16, 8/32 or 32/8. U = 16 if unit16_i, else 32.
- Derived counts: bytes per row = N*U/8; BEATS = N*U/TX_BITS, minimum 1. If N*U < TX_BITS, the upper bits of the beat are zero-filled.
- Beat k of a row: tx_data = captured_row[k*TX_BITS +: TX_BITS]. Bits beyond N*U are 0.
- FSM IDLE:
  - start with shape ≠ 3 → FETCH (row=0, beat=0).
  - start with shape = 3 → DONE; no beats are sent, done pulses once.
  - start while not in IDLE is ignored.
- FSM FETCH: rd_req=1 for exactly one cycle, rd_row=row → WAIT.
- FSM WAIT: capture rd_data into the row buffer at the cycle end → SEND.
- FSM SEND:
  - tx_valid=1.
  - On tx_valid&&tx_ready: beat++.
  - Last beat of a row that is not the last row: row++, beat=0 → FETCH.
  - Last beat of the last row: → DONE.
- FSM DONE: done=1 and busy=0 for one cycle → IDLE.
- Latency and throughput:
  - start sampled at cycle 0 → rd_req at cycle 1 → first tx_valid at cycle 3.
  - Inter-row bubble is 2 cycles (FETCH, WAIT).
  - Last handshake at cycle t → done at t+1.
- Handshake rules:
  - Once tx_valid is high, tx_data and tx_last are held stable until accepted.
  - tx_valid never drops without a handshake, except on reset.
- tx_last = 1 only on beat BEATS-1 of row M-1. It is held with tx_valid.
- shape_i and unit16_i changes after start have no effect until the next start.

Optional Feature:
- Macro: TC_TX_ROWLAST_EN.
- Defined: adds output tx_row_last (1 bit). It is high on beat BEATS-1 of every row, qualified by tx_valid, stable under stall, and 0 on reset.
- Undefined: the port is absent; behaviour is otherwise identical.

Test Plan:
- m16n16, 32-bit units, TX_BITS=128, tx_ready=1:
  - 64 beats; first tx_valid at cycle 3.
  - rd_req pulses 16 times with rd_row 0..15.
  - tx_last only on beat 64; done one cycle later.
  - Data matches row buffer slices.
- m8n32, unit16_i=1:
  - 4 beats per row, 32 beats total.
  - tx_last on beat 32; tx_data[127:0] of beat 0 = elements 0..7, 16-bit each.
- m32n8, 32-bit units with random tx_ready (≈50%):
  - 2 beats per row, 64 beats total.
  - tx_data and tx_last are unchanged across every stalled cycle.
  - No beat is lost or duplicated.
- start pulsed again in the middle of the transfer:
  - Ignored; the beat count stays 64.
  - busy stays high until done.
- rst_n asserted during SEND of row 5:
  - tx_valid, rd_req and busy go 0 immediately.
  - A new start after release restarts from row 0.
- shape_i=3 with start:
  - No rd_req and no tx_valid.
  - done pulses at cycle 2.
  - With TC_TX_ROWLAST_EN in the m16n16 case, tx_row_last pulses on beats 4, 8, …, 64.

Source files
------------

// File: rtl/tc_result_tx.sv
// Tensor-core result transmitter: fetches the C tile row by row from the PE result
// regfile and streams it as TX_BITS-wide beats. Define TC_TX_ROWLAST_EN to add tx_row_last.
module tc_result_tx #(
  parameter int TX_BITS = 128,
  parameter int MAX_N   = 32,
  parameter int UNIT_W  = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [1:0]              shape_i,
  input  logic                    unit16_i,
  output logic                    rd_req,
  output logic [4:0]              rd_row,
  input  logic [MAX_N*UNIT_W-1:0] rd_data,
  output logic                    tx_valid,
  input  logic                    tx_ready,
  output logic [TX_BITS-1:0]      tx_data,
  output logic                    tx_last,
`ifdef TC_TX_ROWLAST_EN
  output logic                    tx_row_last,
`endif
  output logic                    busy,
  output logic                    done
);

  localparam int RD_W  = MAX_N * UNIT_W;
  localparam int NBEAT = (RD_W + TX_BITS - 1) / TX_BITS;
  localparam int BIW   = (NBEAT > 1) ? $clog2(NBEAT) : 1;
  localparam int NSLOT = 1 << BIW;
  localparam int BUF_W = NSLOT * TX_BITS;
  localparam int RBW   = $clog2(RD_W + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_SEND  = 3'd3;
  localparam logic [2:0] S_SKIP  = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  logic [2:0]                    state_q, state_d;
  logic [4:0]                    row_q, row_d, mlast_q;
  logic [BIW-1:0]                beat_q, beat_d, blast_q;
  logic [RBW-1:0]                rbits_q;
  logic [BUF_W-1:0]              buf_q, buf_d;
  logic [RD_W-1:0]               mask;
  logic [NSLOT-1:0][TX_BITS-1:0] slots;
  logic                          beat_end, row_end, sending, accept;

  // Shape decode applied only when a start is accepted
  int             n_el, u_el, m_el;
  logic [RBW-1:0] rbits_s;
  logic [BIW-1:0] blast_s;
  logic [4:0]     mlast_s;

  always_comb begin
    n_el = 16;
    m_el = 16;
    case (shape_i)
      2'd1:    begin n_el = 32; m_el = 8;  end
      2'd2:    begin n_el = 8;  m_el = 32; end
      default: ;
    endcase
    u_el    = unit16_i ? 16 : 32;
    rbits_s = RBW'(n_el * u_el);
    blast_s = BIW'((n_el * u_el + TX_BITS - 1) / TX_BITS - 1);
    mlast_s = 5'(m_el - 1);
  end

  // Row bits beyond N*U are cleared so short rows leave the beat tail zero
  always_comb begin
    mask = '0;
    for (int i = 0; i < RD_W; i++) mask[i] = (i < int'(rbits_q));
  end

  assign accept   = (state_q == S_IDLE) && start;
  assign beat_end = (beat_q == blast_q);
  assign row_end  = (row_q == mlast_q);
  assign sending  = (state_q == S_SEND);

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    beat_d  = beat_q;
    buf_d   = buf_q;
    case (state_q)
      S_IDLE: if (start) begin
        row_d   = '0;
        beat_d  = '0;
        state_d = (shape_i == 2'd3) ? S_SKIP : S_FETCH;
      end
      S_FETCH: state_d = S_WAIT;
      S_WAIT: begin
        buf_d   = BUF_W'(rd_data & mask);
        state_d = S_SEND;
      end
      S_SEND: if (tx_ready) begin
        if (beat_end) begin
          beat_d = '0;
          if (row_end) state_d = S_DONE;
          else begin
            row_d   = row_q + 5'd1;
            state_d = S_FETCH;
          end
        end else begin
          beat_d = beat_q + 1'b1;
        end
      end
      // Illegal shape still spends one busy cycle so done lands two cycles after start
      S_SKIP:  state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      row_q   <= '0;
      beat_q  <= '0;
      buf_q   <= '0;
      rbits_q <= '0;
      blast_q <= '0;
      mlast_q <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      beat_q  <= beat_d;
      buf_q   <= buf_d;
      if (accept) begin
        rbits_q <= rbits_s;
        blast_q <= blast_s;
        mlast_q <= mlast_s;
      end
    end
  end

  assign slots    = buf_q;
  assign rd_req   = (state_q == S_FETCH);
  assign rd_row   = row_q;
  assign tx_valid = sending;
  assign tx_data  = sending ? slots[beat_q] : '0;
  assign tx_last  = sending && beat_end && row_end;
`ifdef TC_TX_ROWLAST_EN
  assign tx_row_last = sending && beat_end;
`endif
  assign busy = (state_q == S_FETCH) || (state_q == S_WAIT) ||
                (state_q == S_SEND)  || (state_q == S_SKIP);
  assign done = (state_q == S_DONE);

endmodule
